video_mode_ctrl: RTL
====================

VIDEO_MODE_CTRL -- requirements
Module: video_mode_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_MODE, default 0, giving the mode selected after reset.
REQ-002 The block SHALL have parameter SETTLE_FRAMES, default 2, range 1..15, giving the number of muted new-mode frames after a switch.
REQ-003 CLK  in  1  pixel clock; the only clock.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 REQ_VALID  in  1  mode-change request valid.
REQ-006 REQ_MODE  in  2  requested mode.
REQ-007 REQ_READY  out  1  request accepted when REQ_VALID and REQ_READY are both high on a CLK edge.
REQ-008 h, v  in  13 each  current position from the timing generator.
REQ-009 H_ACTIVE, H_SYNC_S, H_SYNC_E, H_LAST  out  13 each  horizontal timing for the current MODE.
REQ-010 V_ACTIVE, V_SYNC_S, V_SYNC_E, V_LAST  out  13 each  vertical timing for the current MODE.
REQ-011 MODE  out  2  current mode.
REQ-012 TIMING_LOAD  out  1  one-cycle pulse on the cycle MODE changes; the timing generator restarts at h=0, v=0.
REQ-013 MUTE  out  1  picture blanking request.
REQ-014 DONE  out  1  one-cycle pulse when a request completes.
REQ-015 ERR  out  1  one-cycle pulse when a request is rejected.

Function
REQ-016 The timing outputs SHALL be decoded from MODE (all values are inclusive indices):
- Mode 0, 576p: active 720 x 576; hsync 732..795; H_LAST 863; vsync 581..585; V_LAST 624.
- Mode 1, 480p: active 720 x 480; hsync 736..797; H_LAST 857; vsync 489..494; V_LAST 524.
- Mode 2, VGA: active 640 x 480; hsync 656..751; H_LAST 799; vsync 490..491; V_LAST 524.
- Mode 3: reserved; it never appears on MODE.
REQ-017 FE (frame end) SHALL be 1 when h==H_LAST and v==V_LAST of the current MODE, with exact equality only; out-of-range h/v SHALL never produce FE.
REQ-018 The states SHALL be IDLE, ARMED, DRAIN, SETTLE. REQ_READY SHALL be 1 only in IDLE.
REQ-019 In IDLE, on accept with REQ_MODE==3: pulse ERR on the next cycle; state and MODE unchanged.
REQ-020 In IDLE, on accept with REQ_MODE==MODE: pulse DONE on the next cycle; state stays IDLE; no MUTE, no TIMING_LOAD.
REQ-021 In IDLE, on accept of any other mode: latch it into PEND and go to ARMED.
REQ-022 ARMED: on FE, set MUTE=1 and go to DRAIN. MUTE therefore rises at the frame boundary.
REQ-023 DRAIN: one full old-mode frame is muted. On FE: MODE<=PEND, pulse TIMING_LOAD, clear the frame counter, go to SETTLE.
REQ-024 SETTLE: count FE events of the new mode. On the SETTLE_FRAMES-th FE: MUTE<=0, pulse DONE, go to IDLE.
REQ-025 A request accepted while FE is high in IDLE SHALL NOT arm on that same FE; it waits for the next FE.
REQ-026 REQ_VALID and REQ_MODE SHALL be ignored outside IDLE, with no queuing.
REQ-027 The FE-compare values SHALL switch to the new mode on the cycle after TIMING_LOAD.
REQ-028 All outputs SHALL be registered except the timing outputs, which are a pure decode of the MODE register.
REQ-029 The SETTLE frame counter SHALL be 4 bits and SHALL NOT wrap.

Reset
REQ-030 While RST_N=0 the block SHALL force: state IDLE, MODE=RESET_MODE, MUTE=0, TIMING_LOAD=0, DONE=0, ERR=0, PEND=RESET_MODE, frame counter=0.
REQ-031 Assertion of RST_N mid-switch SHALL abandon the switch: MODE returns to RESET_MODE and MUTE drops immediately, asynchronously.
REQ-032 REQ_READY SHALL be 1 on the first edge after RST_N deasserts.

Verification
REQ-033 Reset, then hold REQ_VALID=0 -> MODE=0, H_LAST=863, V_LAST=624, MUTE=0, REQ_READY=1.
REQ-034 Request mode 1 in mode 0, with h/v driven by a model counter -> MUTE rises the cycle after h=863,v=624, one frame later. TIMING_LOAD pulses after the next FE and MODE=1. MUTE falls and DONE pulses after the 2nd FE at h=857,v=524.
REQ-035 Request mode 3 -> ERR pulses once; MODE, MUTE and REQ_READY are unchanged.
REQ-036 Request mode 0 while in mode 0 -> DONE pulses on the next cycle; MUTE and TIMING_LOAD never assert.
REQ-037 Assert RST_N=0 during SETTLE after a 0->2 switch -> MODE=0 and MUTE=0 immediately; after release, REQ_READY=1.
REQ-038 Hold REQ_VALID=1 with mode 2 during DRAIN -> no second accept. Only one TIMING_LOAD pulse occurs, and REQ_READY returns to 1 only with DONE.

Source files
------------

// File: rtl/video_mode_ctrl.sv
// Video mode controller: decodes timing for the active mode and
// sequences a muted, frame-aligned switch to a newly requested mode.
module video_mode_ctrl #(
    parameter int RESET_MODE    = 0,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    input  logic [1:0]  REQ_MODE,
    output logic        REQ_READY,
    input  logic [12:0] h,
    input  logic [12:0] v,
    output logic [12:0] H_ACTIVE,
    output logic [12:0] H_SYNC_S,
    output logic [12:0] H_SYNC_E,
    output logic [12:0] H_LAST,
    output logic [12:0] V_ACTIVE,
    output logic [12:0] V_SYNC_S,
    output logic [12:0] V_SYNC_E,
    output logic [12:0] V_LAST,
    output logic [1:0]  MODE,
    output logic        TIMING_LOAD,
    output logic        MUTE,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DRAIN,
        SETTLE
    } state_t;

    localparam logic [1:0] RST_MODE = 2'(RESET_MODE);
    localparam logic [3:0] SETTLE_N = 4'(SETTLE_FRAMES);

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  pend_q, pend_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mute_q, mute_d;
    logic        tl_q, tl_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        fe;

    // Timing parameters are a pure decode of the current mode register
    always_comb begin
        H_ACTIVE = 13'd720;
        H_SYNC_S = 13'd732;
        H_SYNC_E = 13'd795;
        H_LAST   = 13'd863;
        V_ACTIVE = 13'd576;
        V_SYNC_S = 13'd581;
        V_SYNC_E = 13'd585;
        V_LAST   = 13'd624;
        unique case (mode_q)
            2'd1: begin
                H_ACTIVE = 13'd720;
                H_SYNC_S = 13'd736;
                H_SYNC_E = 13'd797;
                H_LAST   = 13'd857;
                V_ACTIVE = 13'd480;
                V_SYNC_S = 13'd489;
                V_SYNC_E = 13'd494;
                V_LAST   = 13'd524;
            end
            2'd2: begin
                H_ACTIVE = 13'd640;
                H_SYNC_S = 13'd656;
                H_SYNC_E = 13'd751;
                H_LAST   = 13'd799;
                V_ACTIVE = 13'd480;
                V_SYNC_S = 13'd490;
                V_SYNC_E = 13'd491;
                V_LAST   = 13'd524;
            end
            default: begin
                H_ACTIVE = 13'd720;
            end
        endcase
    end

    // Frame end only on exact match with the current mode's last indices
    assign fe = (h == H_LAST) && (v == V_LAST);

    // Next-state and registered-output logic for the switch sequencer
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        mute_d  = mute_q;
        tl_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    if (REQ_MODE == 2'd3) begin
                        err_d = 1'b1;
                    end else if (REQ_MODE == mode_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = REQ_MODE;
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (fe) begin
                    mute_d  = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fe) begin
                    mode_d  = pend_q;
                    tl_d    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (fe) begin
                    if (cnt_q != 4'hF) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (cnt_q == SETTLE_N - 4'd1) begin
                        mute_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and output registers; reset abandons any switch in progress
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            mode_q  <= RST_MODE;
            pend_q  <= RST_MODE;
            cnt_q   <= 4'd0;
            mute_q  <= 1'b0;
            tl_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            mute_q  <= mute_d;
            tl_q    <= tl_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign MODE        = mode_q;
    assign MUTE        = mute_q;
    assign TIMING_LOAD = tl_q;
    assign DONE        = done_q;
    assign ERR         = err_q;
    assign REQ_READY   = ready_q;

endmodule
